// File: rtl/sw_word_loader_pkg.sv
// Shared types and constants for the switch-driven 32-bit word loader.
package sw_word_loader_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Returns word with the selected byte lane replaced by value.
  function automatic logic [WORD_W-1:0] write_lane(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lane,
    input logic [BYTE_W-1:0] value
  );
    logic [WORD_W-1:0] result;
    result = word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane == 2'(i)) result[i*BYTE_W +: BYTE_W] = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/sw_word_loader_if.sv
// Valid/ready word handshake between the loader (master) and the CPU-side consumer (slave).
interface sw_word_loader_if;
  import sw_word_loader_pkg::*;

  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/sw_word_loader_btn_pulse.sv
// Raw push button to one-cycle press pulse: 2-flop synchronizer, counting debouncer, registered edge detect.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/sw_word_loader.sv
// Assembles a 32-bit word from the slide switches one byte per debounced press and offers it over valid/ready.
// Optional feature macro: SW_LOADER_ECHO_EN (LED echoes last captured byte instead of status).
module sw_word_loader
  import sw_word_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  input  logic                  btn,
  input  logic                  btn_clr,
  input  logic [BYTE_W-1:0]     SW,
  sw_word_loader_if.master      bus,
  output logic [1:0]            byte_idx,
  output logic [BYTE_W-1:0]     LED
);

  logic load_pulse;
  logic clr_pulse;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk   (clk_100MHz),
    .rst   (rst),
    .raw   (btn),
    .pulse (load_pulse)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk   (clk_100MHz),
    .rst   (rst),
    .raw   (btn_clr),
    .pulse (clr_pulse)
  );

  state_t            state, state_next;
  logic [WORD_W-1:0] word, word_next;
  logic              valid, valid_next;
  logic [1:0]        idx, idx_next;

`ifdef SW_LOADER_ECHO_EN
  logic [BYTE_W-1:0] echo, echo_next;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state <= COLLECT;
      word  <= '0;
      valid <= 1'b0;
      idx   <= '0;
`ifdef SW_LOADER_ECHO_EN
      echo  <= '0;
`endif
    end else begin
      state <= state_next;
      word  <= word_next;
      valid <= valid_next;
      idx   <= idx_next;
`ifdef SW_LOADER_ECHO_EN
      echo  <= echo_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    word_next  = word;
    valid_next = valid;
    idx_next   = idx;
`ifdef SW_LOADER_ECHO_EN
    echo_next  = echo;
`endif
    // Clear overrides everything; a coincident handshake ends in the same cleared state.
    if (clr_pulse) begin
      state_next = COLLECT;
      word_next  = '0;
      valid_next = 1'b0;
      idx_next   = '0;
`ifdef SW_LOADER_ECHO_EN
      echo_next  = '0;
`endif
    end else begin
      unique case (state)
        COLLECT: begin
          if (load_pulse) begin
            word_next = write_lane(word, idx, SW);
            idx_next  = idx + 2'd1;
`ifdef SW_LOADER_ECHO_EN
            echo_next = SW;
`endif
            if (idx == 2'd3) begin
              valid_next = 1'b1;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (valid && bus.word_ready) begin
            valid_next = 1'b0;
            state_next = COLLECT;
          end
        end
        default: state_next = COLLECT;
      endcase
    end
  end

  assign bus.word_out   = word;
  assign bus.word_valid = valid;
  assign byte_idx       = idx;

`ifdef SW_LOADER_ECHO_EN
  assign LED = echo;
`else
  assign LED = {valid, 5'b0, idx};
`endif

endmodule

// File: tb/tb_sw_word_loader.sv
// Directed bench for sw_word_loader with a short debounce window; honours SW_LOADER_ECHO_EN for LED checks.
module tb_sw_word_loader;
  import sw_word_loader_pkg::*;

  logic        clk_100MHz;
  logic        rst;
  logic        btn;
  logic        btn_clr;
  logic [7:0]  SW;
  logic [1:0]  byte_idx;
  logic [7:0]  LED;

  int checks;
  int errors;

  sw_word_loader_if bus ();

  sw_word_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .btn        (btn),
    .btn_clr    (btn_clr),
    .SW         (SW),
    .bus        (bus.master),
    .byte_idx   (byte_idx),
    .LED        (LED)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic press(input logic [7:0] v);
    SW  = v;
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic clear_press();
    btn_clr = 1'b1;
    repeat (10) tick();
    btn_clr = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.word_out !== 32'h0) begin
      errors++; $display("FAIL reset_word: got %h expected %h", bus.word_out, 32'h0);
    end
    checks++;
    if (bus.word_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.word_valid);
    end
    checks++;
    if (byte_idx !== 2'd0) begin
      errors++; $display("FAIL reset_idx: got %0d expected 0", byte_idx);
    end
    checks++;
    if (LED !== 8'h00) begin
      errors++; $display("FAIL reset_led: got %h expected 00", LED);
    end
  endtask

  task automatic test_load_word();
    // First press: btn sampled at the next edge, lane visible after the 8th edge.
    SW  = 8'h78;
    btn = 1'b1;
    repeat (7) tick();
    checks++;
    if (byte_idx !== 2'd0) begin
      errors++; $display("FAIL latency_early: idx got %0d expected 0", byte_idx);
    end
    tick();
    checks++;
    if (byte_idx !== 2'd1 || bus.word_out !== 32'h0000_0078) begin
      errors++; $display("FAIL latency_load: idx %0d word %h expected 1 00000078", byte_idx, bus.word_out);
    end
    repeat (2) tick();
    btn = 1'b0;
    repeat (10) tick();
    checks++;
    if (byte_idx !== 2'd1) begin
      errors++; $display("FAIL release_no_load: idx got %0d expected 1", byte_idx);
    end
    press(8'h56);
    press(8'h34);
    checks++;
    if (byte_idx !== 2'd3 || bus.word_valid !== 1'b0) begin
      errors++; $display("FAIL three_loads: idx %0d valid %b expected 3 0", byte_idx, bus.word_valid);
    end
    press(8'h12);
    checks++;
    if (bus.word_out !== 32'h1234_5678 || bus.word_valid !== 1'b1 || byte_idx !== 2'd0) begin
      errors++; $display("FAIL full_word: word %h valid %b idx %0d expected 12345678 1 0",
                         bus.word_out, bus.word_valid, byte_idx);
    end
`ifndef SW_LOADER_ECHO_EN
    checks++;
    if (LED !== 8'h80) begin
      errors++; $display("FAIL led_hold: got %h expected 80", LED);
    end
`endif
    press(8'hEE);
    checks++;
    if (bus.word_out !== 32'h1234_5678 || bus.word_valid !== 1'b1 || byte_idx !== 2'd0) begin
      errors++; $display("FAIL hold_ignores_load: word %h valid %b idx %0d expected 12345678 1 0",
                         bus.word_out, bus.word_valid, byte_idx);
    end
  endtask

  task automatic test_handshake();
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    checks++;
    if (bus.word_valid !== 1'b0 || byte_idx !== 2'd0 || bus.word_out !== 32'h1234_5678) begin
      errors++; $display("FAIL handshake: valid %b idx %0d word %h expected 0 0 12345678",
                         bus.word_valid, byte_idx, bus.word_out);
    end
    press(8'hAA);
    checks++;
    if (bus.word_out !== 32'h1234_56AA || byte_idx !== 2'd1) begin
      errors++; $display("FAIL overwrite_lane0: word %h idx %0d expected 123456AA 1", bus.word_out, byte_idx);
    end
    bus.word_ready = 1'b1;
    repeat (3) tick();
    bus.word_ready = 1'b0;
    checks++;
    if (bus.word_valid !== 1'b0 || byte_idx !== 2'd1) begin
      errors++; $display("FAIL ready_idle: valid %b idx %0d expected 0 1", bus.word_valid, byte_idx);
    end
  endtask

  task automatic test_bounce();
    clear_press();
    checks++;
    if (bus.word_out !== 32'h0 || byte_idx !== 2'd0) begin
      errors++; $display("FAIL clear: word %h idx %0d expected 0 0", bus.word_out, byte_idx);
    end
    SW = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (2) tick();
    end
    btn = 1'b1;
    repeat (12) tick();
    btn = 1'b0;
    repeat (12) tick();
    checks++;
    if (byte_idx !== 2'd1 || bus.word_out !== 32'h0000_003C) begin
      errors++; $display("FAIL bounce: idx %0d word %h expected 1 0000003C", byte_idx, bus.word_out);
    end
  endtask

  task automatic test_led();
    clear_press();
    press(8'h5A);
`ifdef SW_LOADER_ECHO_EN
    checks++;
    if (LED !== 8'h5A) begin
      errors++; $display("FAIL led_echo: got %h expected 5A", LED);
    end
`endif
    press(8'h11);
`ifdef SW_LOADER_ECHO_EN
    checks++;
    if (LED !== 8'h11) begin
      errors++; $display("FAIL led_echo2: got %h expected 11", LED);
    end
`else
    checks++;
    if (LED !== 8'h02) begin
      errors++; $display("FAIL led_status: got %h expected 02", LED);
    end
`endif
  endtask

  task automatic test_clr_collision();
    SW      = 8'hFF;
    btn     = 1'b1;
    btn_clr = 1'b1;
    repeat (10) tick();
    btn     = 1'b0;
    btn_clr = 1'b0;
    repeat (10) tick();
    checks++;
    if (byte_idx !== 2'd0 || bus.word_out !== 32'h0 || bus.word_valid !== 1'b0) begin
      errors++; $display("FAIL clr_wins: idx %0d word %h valid %b expected 0 0 0",
                         byte_idx, bus.word_out, bus.word_valid);
    end
    checks++;
    if (LED !== 8'h00) begin
      errors++; $display("FAIL clr_led: got %h expected 00", LED);
    end
  endtask

  task automatic test_clear_in_hold();
    press(8'h01);
    press(8'h02);
    press(8'h03);
    press(8'h04);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h0403_0201) begin
      errors++; $display("FAIL refill: valid %b word %h expected 1 04030201", bus.word_valid, bus.word_out);
    end
    clear_press();
    checks++;
    if (bus.word_valid !== 1'b0 || bus.word_out !== 32'h0 || byte_idx !== 2'd0) begin
      errors++; $display("FAIL clear_hold: valid %b word %h idx %0d expected 0 0 0",
                         bus.word_valid, bus.word_out, byte_idx);
    end
  endtask

  task automatic test_reset_midword();
    press(8'h99);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (byte_idx !== 2'd0 || bus.word_out !== 32'h0) begin
      errors++; $display("FAIL reset_midword: idx %0d word %h expected 0 0", byte_idx, bus.word_out);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    btn            = 1'b0;
    btn_clr        = 1'b0;
    SW             = 8'h00;
    bus.word_ready = 1'b0;
    test_reset();
    test_load_word();
    test_handshake();
    test_bounce();
    test_led();
    test_clr_collision();
    test_clear_in_hold();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_word_loader.md
# sw_word_loader

Operator-input front end for the single-step CPU board: assembles a 32-bit word from the 8 slide switches, one byte per debounced button press, and offers it to the CPU-side consumer over a valid/ready handshake. It is the write-direction counterpart of the byte-selected LED result display. It sits at the top level beside the CPU and shares the board clock.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles required before a button level change is accepted (10 ms at 100 MHz)
- clk_100MHz  input  1  board clock; all logic is on its rising edge
- rst  input  1  synchronous, active-high reset
- btn  input  1  raw "load byte" push button, asynchronous, bouncy
- btn_clr  input  1  raw "abort word" push button, asynchronous, bouncy
- SW  input  8  byte value to load
- word_ready  input  1  consumer accepts word this cycle
- word_out  output  32  assembled word; byte 0 in [7:0], byte 3 in [31:24]
- word_valid  output  1  word_out is complete and held
- byte_idx  output  2  lane to be written by the next press
- LED  output  8  status / echo (see Configuration)

## Operation
- Each raw button passes through a 2-flop synchronizer, then a debouncer. The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle reloads the counter. A registered rising-edge detector produces a one-cycle press pulse.
- States:
  - COLLECT (reset state)
  - HOLD
- COLLECT:
  - A load pulse writes SW into lane byte_idx of word_out and increments byte_idx.
  - A load pulse while byte_idx==3 writes lane 3, wraps byte_idx to 0, sets word_valid and enters HOLD.
- HOLD:
  - word_out and word_valid are frozen. Load pulses are ignored (not queued).
  - word_valid && word_ready clears word_valid and returns to COLLECT. word_out keeps its value until it is overwritten lane by lane.
- Clear pulse, in either state: byte_idx←0, word_valid←0, state←COLLECT, word_out←0.
- A clear pulse and a load pulse in the same cycle: clear wins, and the load is discarded.
- A clear pulse and a handshake in the same cycle: the handshake completes, and the clear also applies. The end state is identical.
- word_ready while word_valid==0 has no effect.
- Reset values: word_out=0, word_valid=0, byte_idx=0, LED=0, state COLLECT, debounced levels 0, counters 0. Reset mid-word discards partial bytes. A button held through reset release produces a press only after DEBOUNCE_CYCLES.

## Timing
- Raw btn rising and staying stable at edge N produces the press pulse high during cycle N+DEBOUNCE_CYCLES+3:
  - 2 cycles synchronizer
  - DEBOUNCE_CYCLES cycles count
  - 1 cycle edge register
- Captured byte and new byte_idx are visible one cycle after the pulse cycle.
- word_valid rises on the same edge that writes lane 3.
- Handshake completes on the edge where word_valid and word_ready are both high. word_valid is low the cycle after.
- Release of a held button never produces a pulse. One physical press produces at most one load.

## Configuration
- SW_LOADER_ECHO_EN defined: LED shows the most recently captured byte (0 after reset or clear).
- SW_LOADER_ECHO_EN undefined:
  - LED[7] = word_valid
  - LED[1:0] = byte_idx
  - LED[6:2] = 0
- The state machine and handshake are identical in both builds.

## Structure
- Shared package holds:
  - state encoding constants (COLLECT=1'b0, HOLD=1'b1)
  - lane count (4)
  - byte width (8)
- One sub-module, btn_pulse (synchronizer + debouncer + edge detector, parameter DEBOUNCE_CYCLES), instantiated twice: once for btn, once for btn_clr.
- The loader FSM, lane write and LED mux stay in sw_word_loader.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset held 3 cycles → word_out=0, word_valid=0, byte_idx=0, LED=0.
- Four clean presses with SW=0x78, 0x56, 0x34, 0x12, word_ready=0 → word_valid=1, word_out=0x12345678. The pulse comes 7 cycles after each btn rise. A fifth press leaves word_out unchanged.
- Bounce btn 1/0 every 2 cycles for 20 cycles, then hold high → exactly one load, byte_idx 0→1.
- Assert word_ready in HOLD → word_valid low the next cycle, byte_idx=0. The next press with SW=0xAA gives word_out=0x123456AA.
- After two loads, btn_clr and btn press pulses land in the same cycle → byte_idx=0, word_out=0, no byte written.
- With SW_LOADER_ECHO_EN, load SW=0x5A → LED=0x5A. Without it, after two loads → LED=0x02, and in HOLD → LED=0x80.
